rng_request_arbiter: RTL



---
 rtl/rng_request_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/rng_request_arbiter.sv
// Round-robin arbiter that shares one 2-bit randomizer stream and hands out WORD_W-bit words.
// Optional repeat-count health check and HALT state are compiled in with `define RNG_HEALTH_CHECK_EN.
module rng_request_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int WORD_W       = 8,
   parameter int WARMUP_CYC   = 16,
   parameter int REPEAT_LIMIT = 8
) (
   input  logic               i_clk,
   input  logic               i_reset_n,
   input  logic [NUM_REQ-1:0] i_req,
   output logic [NUM_REQ-1:0] o_ack,
   output logic [WORD_W-1:0]  o_word,
   output logic               o_rng_en,
   input  logic [1:0]         i_rng_bits,
   output logic               o_busy,
   output logic               o_health_fail
);

   localparam int SYM     = WORD_W / 2;
   localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_MAX = (WARMUP_CYC > SYM) ? WARMUP_CYC : SYM;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {
      ST_WARMUP,
      ST_IDLE,
      ST_FILL,
`ifdef RNG_HEALTH_CHECK_EN
      ST_HALT,
`endif
      ST_DELIVER
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [IDX_W-1:0]    grant_q, grant_d;
   logic [IDX_W-1:0]    rr_q, rr_d;
   logic [WORD_W-1:0]   shift_q, shift_d;
   logic [WORD_W-1:0]   word_q, word_d;
   logic                en_q, en_d;
   logic [IDX_W-1:0]    pick;
   logic                trip;

   // First set request at or after the RR pointer: scanning downwards lets the nearest one win.
   always_comb begin
      pick = rr_q;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (i_req[(int'(rr_q) + k) % NUM_REQ]) pick = IDX_W'((int'(rr_q) + k) % NUM_REQ);
      end
   end

`ifdef RNG_HEALTH_CHECK_EN
   localparam int REP_W = $clog2(REPEAT_LIMIT + 1);

   logic [1:0]       prev_q;
   logic [REP_W-1:0] rep_q, rep_d;
   logic             fail_q;

   // A zero count means no symbol has been captured since reset, so the first one starts a run of 1.
   always_comb begin
      rep_d = rep_q;
      trip  = 1'b0;
      if (en_q) begin
         rep_d = (rep_q != '0 && i_rng_bits == prev_q) ? rep_q + REP_W'(1) : REP_W'(1);
         trip  = (rep_d == REP_W'(REPEAT_LIMIT));
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         prev_q <= '0;
         rep_q  <= '0;
         fail_q <= 1'b0;
      end else begin
         if (en_q) prev_q <= i_rng_bits;
         rep_q  <= rep_d;
         fail_q <= fail_q | trip;
      end
   end

   assign o_health_fail = fail_q;
`else
   logic unused_repeat_limit;
   assign unused_repeat_limit = (REPEAT_LIMIT > 0);
   assign trip                = 1'b0;
   assign o_health_fail       = 1'b0;
`endif

   always_comb begin
      // NOTE: every variable gets a default before the case, so no path can infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      grant_d = grant_q;
      rr_d    = rr_q;
      shift_d = shift_q;
      word_d  = word_q;
      o_ack   = '0;
      o_word  = word_q;
      case (state_q)
         ST_WARMUP: begin
            if (en_q) begin
               if (cnt_q == CNT_W'(WARMUP_CYC - 1)) begin
                  cnt_d   = '0;
                  state_d = ST_IDLE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         ST_IDLE: begin
            if (|i_req) begin
               grant_d = pick;
               cnt_d   = '0;
               state_d = ST_FILL;
            end
         end
         ST_FILL: begin
            shift_d = WORD_W'({shift_q, i_rng_bits});
            if (cnt_q == CNT_W'(SYM - 1)) begin
               cnt_d   = '0;
               state_d = ST_DELIVER;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_DELIVER: begin
            if (i_req[grant_q]) begin
               o_ack[grant_q] = 1'b1;
               o_word         = shift_q;
               word_d         = shift_q;
            end
            rr_d    = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);
            state_d = ST_IDLE;
         end
`ifdef RNG_HEALTH_CHECK_EN
         ST_HALT: state_d = ST_HALT;
`endif
         default: state_d = ST_WARMUP;
      endcase
`ifdef RNG_HEALTH_CHECK_EN
      if (trip) state_d = ST_HALT;
`endif
   end

   // The enable is registered so it is low in reset and rises on the first edge after release.
   assign en_d = (state_d == ST_WARMUP) || (state_d == ST_FILL);

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= ST_WARMUP;
         cnt_q   <= '0;
         grant_q <= '0;
         rr_q    <= '0;
         shift_q <= '0;
         word_q  <= '0;
         en_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the pre-edge values together.
         state_q <= state_d;
         cnt_q   <= cnt_d;
         grant_q <= grant_d;
         rr_q    <= rr_d;
         shift_q <= shift_d;
         word_q  <= word_d;
         en_q    <= en_d;
      end
   end

   assign o_rng_en = en_q;
   assign o_busy   = (state_q != ST_IDLE);

   logic unused_trip;
   assign unused_trip = trip;

endmodule
